// File: rtl/clkdiv_ctrl.sv
// -----------------------------------------------------------------------------
// clkdiv_ctrl : programmable, glitch-free clock-divider controller.
//
// Produces a registered divided clock (clk_out) from sys_clk with a ratio that
// can be changed at run time. New ratios are offered over a valid/ready
// handshake and only take effect on a period boundary. Start and stop also
// happen only on period boundaries, so clk_out never shows a truncated pulse.
//
// Ports:
//   sys_clk    in   system clock, all logic on rising edge
//   sys_rst_n  in   synchronous active-low reset
//   en         in   run request (1 = run, 0 = stop at end of current period)
//   cfg_valid  in   new ratio offered
//   cfg_div    in   requested ratio N (DIV_W bits)
//   cfg_ready  out  controller accepts a ratio this cycle (STOP or RUN)
//   cfg_err    out  one-cycle pulse: an accepted ratio was rejected (N < 2)
//   cfg_done   out  one-cycle pulse: a new ratio is now in effect
//   cur_div    out  ratio currently in effect
//   clk_out    out  divided clock, registered
//   tick       out  one-cycle pulse on the cycle clk_out rises
//   running    out  1 while in RUN or PEND
//   dbg_state  out  FSM state (0 = STOP, 1 = RUN, 2 = PEND)
//
// Handshake: a ratio transfers on any rising edge where cfg_valid and
// cfg_ready are both high. cfg_ready depends only on the registered state,
// never on cfg_valid, and the offer may be withdrawn at any time before the
// transfer edge.
//
// Period rule (N = cur_div, half = N >> 1): the counter runs 0..N-1, and
// clk_out is registered as (next count < half), giving half cycles high and
// N-half cycles low. The cycle with count N-1 is the wrap cycle; clk_out is
// always low there.
// -----------------------------------------------------------------------------
module clkdiv_ctrl #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 10
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             cfg_done,
  output logic [DIV_W-1:0] cur_div,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_cur_div;
  logic [DIV_W-1:0] r_pend_div;
  logic             r_clk_out;
  logic             r_tick;
  logic             r_cfg_err;
  logic             r_cfg_done;

  logic             w_wrap;
  logic [DIV_W-1:0] w_half;
  logic [DIV_W-1:0] w_cnt_next;
  logic             w_clk_next;
  logic             w_xfer;
  logic             w_cfg_bad;
  logic             w_xfer_ok;

  // Period bookkeeping for the ratio currently in effect.
  assign w_wrap     = (r_cnt == (r_cur_div - DIV_W'(1)));
  assign w_half     = r_cur_div >> 1;
  assign w_cnt_next = w_wrap ? '0 : (r_cnt + DIV_W'(1));
  assign w_clk_next = (w_cnt_next < w_half);

  // Handshake decode. Ratios below 2 cannot form a period and are rejected.
  assign cfg_ready  = (r_state != ST_PEND);
  assign w_xfer     = cfg_valid & cfg_ready;
  assign w_cfg_bad  = (cfg_div < DIV_W'(2));
  assign w_xfer_ok  = w_xfer & ~w_cfg_bad;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state    <= ST_STOP;
      r_cnt      <= '0;
      r_cur_div  <= DIV_W'(DEFAULT_DIV);
      r_pend_div <= '0;
      r_clk_out  <= 1'b0;
      r_tick     <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_cfg_done <= 1'b0;
    end else begin
      // Pulses default low and are raised only on the cycle that needs them.
      r_tick     <= 1'b0;
      r_cfg_done <= 1'b0;
      r_cfg_err  <= w_xfer & w_cfg_bad;

      case (r_state)
        ST_STOP: begin
          r_cnt <= '0;
          // A ratio accepted while stopped takes effect immediately, so a
          // simultaneous start already uses the new ratio.
          if (w_xfer_ok) begin
            r_cur_div  <= cfg_div;
            r_cfg_done <= 1'b1;
          end
          if (en) begin
            // Count 0 is always below half because every legal ratio is
            // at least 2, so the first cycle of a period is high.
            r_state   <= ST_RUN;
            r_clk_out <= 1'b1;
            r_tick    <= 1'b1;
          end else begin
            r_clk_out <= 1'b0;
          end
        end

        ST_RUN: begin
          if (w_wrap && !en) begin
            // Stop at the period boundary; clk_out is already low here.
            r_state   <= ST_STOP;
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            // A ratio accepted on the stopping edge has no further period to
            // wait for, so it is applied straight away as in STOP.
            if (w_xfer_ok) begin
              r_cur_div  <= cfg_div;
              r_cfg_done <= 1'b1;
            end
          end else begin
            r_cnt     <= w_cnt_next;
            r_clk_out <= w_clk_next;
            r_tick    <= w_wrap;
            // The new ratio waits for the end of the next full period, even
            // when accepted on the wrap cycle itself.
            if (w_xfer_ok) begin
              r_pend_div <= cfg_div;
              r_state    <= ST_PEND;
            end
          end
        end

        ST_PEND: begin
          if (w_wrap) begin
            r_cur_div  <= r_pend_div;
            r_cfg_done <= 1'b1;
            r_cnt      <= '0;
            if (en) begin
              r_state   <= ST_RUN;
              r_clk_out <= 1'b1;
              r_tick    <= 1'b1;
            end else begin
              r_state   <= ST_STOP;
              r_clk_out <= 1'b0;
            end
          end else begin
            r_cnt     <= w_cnt_next;
            r_clk_out <= w_clk_next;
          end
        end

        default: begin
          r_state   <= ST_STOP;
          r_cnt     <= '0;
          r_clk_out <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_err   = r_cfg_err;
  assign cfg_done  = r_cfg_done;
  assign cur_div   = r_cur_div;
  assign clk_out   = r_clk_out;
  assign tick      = r_tick;
  assign running   = (r_state == ST_RUN) || (r_state == ST_PEND);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
module tb_clkdiv_ctrl;

  localparam int DIV_W = 8;
  localparam int DEF_DIV = 4;

  localparam logic [1:0] S_STOP = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PEND = 2'd2;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n;
  logic             en;
  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;
  logic             cfg_done;
  logic [DIV_W-1:0] cur_div;
  logic             clk_out;
  logic             tick;
  logic             running;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  clkdiv_ctrl #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEF_DIV)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .cfg_done  (cfg_done),
    .cur_div   (cur_div),
    .clk_out   (clk_out),
    .tick      (tick),
    .running   (running),
    .dbg_state (dbg_state)
  );

  // Clock / watchdog
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Checking and driver tasks
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock edge; outputs are then sampled 1ns after it.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Walk one full period of ratio n starting at its count-0 cycle and check
  // the expected waveform: n/2 cycles high then low, tick only on the first.
  task automatic run_period(input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("clk_out[n=%0d,i=%0d]", n, i), 32'(clk_out), 32'(i < n / 2));
      chk($sformatf("tick[n=%0d,i=%0d]", n, i), 32'(tick), 32'(i == 0));
      step();
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;

    // Reset
    step();
    step();
    chk("rst clk_out", 32'(clk_out), 32'd0);
    chk("rst tick", 32'(tick), 32'd0);
    chk("rst cur_div", 32'(cur_div), 32'd4);
    chk("rst running", 32'(running), 32'd0);
    chk("rst cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst cfg_err", 32'(cfg_err), 32'd0);
    chk("rst cfg_done", 32'(cfg_done), 32'd0);
    chk("rst state", 32'(dbg_state), 32'(S_STOP));

    // 1: run with default ratio 4 -> 1,1,0,0
    sys_rst_n = 1'b1;
    en = 1'b1;
    step();
    chk("t1 running", 32'(running), 32'd1);
    run_period(4);
    run_period(4);
    chk("t1 cur_div", 32'(cur_div), 32'd4);

    // 3: rejected ratios 1 and 0
    step();                          // cnt=1
    cfg_valid = 1'b1; cfg_div = 8'd1;
    step();                          // cnt=2
    cfg_valid = 1'b0;
    chk("t3 err1 pulse", 32'(cfg_err), 32'd1);
    chk("t3 err1 state", 32'(dbg_state), 32'(S_RUN));
    chk("t3 err1 clk", 32'(clk_out), 32'd0);
    step();                          // cnt=3
    chk("t3 err1 gone", 32'(cfg_err), 32'd0);
    step();                          // cnt=0
    chk("t3 tick", 32'(tick), 32'd1);
    cfg_valid = 1'b1; cfg_div = 8'd0;
    step();                          // cnt=1
    cfg_valid = 1'b0;
    chk("t3 err0 pulse", 32'(cfg_err), 32'd1);
    chk("t3 err0 clk", 32'(clk_out), 32'd1);
    step();                          // cnt=2
    chk("t3 err0 gone", 32'(cfg_err), 32'd0);
    chk("t3 cur_div", 32'(cur_div), 32'd4);
    chk("t3 no done", 32'(cfg_done), 32'd0);
    step();
    step();                          // cnt=0
    run_period(4);

    // 2: ratio 6 offered mid-period while running at 4
    chk("t2 start clk", 32'(clk_out), 32'd1);
    step();                          // cnt=1
    cfg_valid = 1'b1; cfg_div = 8'd6;
    step();                          // cnt=2, PEND
    cfg_valid = 1'b0;
    chk("t2 ready low", 32'(cfg_ready), 32'd0);
    chk("t2 state pend", 32'(dbg_state), 32'(S_PEND));
    chk("t2 running", 32'(running), 32'd1);
    chk("t2 cur old", 32'(cur_div), 32'd4);
    chk("t2 clk cnt2", 32'(clk_out), 32'd0);
    chk("t2 no done yet", 32'(cfg_done), 32'd0);
    step();                          // cnt=3 wrap
    chk("t2 clk wrap", 32'(clk_out), 32'd0);
    chk("t2 no done wrap", 32'(cfg_done), 32'd0);
    step();                          // new period
    chk("t2 done", 32'(cfg_done), 32'd1);
    chk("t2 cur new", 32'(cur_div), 32'd6);
    chk("t2 ready back", 32'(cfg_ready), 32'd1);
    chk("t2 state run", 32'(dbg_state), 32'(S_RUN));
    run_period(6);
    chk("t2 done once", 32'(cfg_done), 32'd0);

    // 4: switch to 5, then drop en at cnt=1
    cfg_valid = 1'b1; cfg_div = 8'd5;
    step();                          // cnt=1, PEND
    cfg_valid = 1'b0;
    repeat (5) step();               // finish old 6-cycle period
    chk("t4 cur 5", 32'(cur_div), 32'd5);
    chk("t4 done", 32'(cfg_done), 32'd1);
    chk("t4 tick", 32'(tick), 32'd1);
    step();                          // cnt=1
    chk("t4 clk cnt1", 32'(clk_out), 32'd1);
    en = 1'b0;
    step();                          // cnt=2
    chk("t4 clk cnt2", 32'(clk_out), 32'd0);
    chk("t4 run cnt2", 32'(running), 32'd1);
    step();                          // cnt=3
    chk("t4 clk cnt3", 32'(clk_out), 32'd0);
    step();                          // cnt=4 wrap
    chk("t4 clk cnt4", 32'(clk_out), 32'd0);
    chk("t4 run cnt4", 32'(running), 32'd1);
    step();                          // STOP
    chk("t4 stopped", 32'(running), 32'd0);
    chk("t4 state", 32'(dbg_state), 32'(S_STOP));
    chk("t4 no tick", 32'(tick), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t4 idle clk %0d", i), 32'(clk_out), 32'd0);
      step();
    end

    // 5: ratio 3 and start on the same edge
    en = 1'b1; cfg_valid = 1'b1; cfg_div = 8'd3;
    step();
    cfg_valid = 1'b0;
    chk("t5 done", 32'(cfg_done), 32'd1);
    chk("t5 cur", 32'(cur_div), 32'd3);
    chk("t5 state", 32'(dbg_state), 32'(S_RUN));
    run_period(3);
    chk("t5 done once", 32'(cfg_done), 32'd0);

    // 6: reset while a ratio is pending
    cfg_valid = 1'b1; cfg_div = 8'd7;
    step();                          // cnt=1, PEND
    cfg_valid = 1'b0;
    chk("t6 pend", 32'(dbg_state), 32'(S_PEND));
    sys_rst_n = 1'b0;
    step();
    chk("t6 clk", 32'(clk_out), 32'd0);
    chk("t6 cur", 32'(cur_div), 32'd4);
    chk("t6 state", 32'(dbg_state), 32'(S_STOP));
    chk("t6 done", 32'(cfg_done), 32'd0);
    chk("t6 running", 32'(running), 32'd0);
    sys_rst_n = 1'b1; en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t6 no done %0d", i), 32'(cfg_done), 32'd0);
      chk($sformatf("t6 idle clk %0d", i), 32'(clk_out), 32'd0);
    end
    chk("t6 cur kept", 32'(cur_div), 32'd4);

    // 7: minimum ratio 2, then a ratio offered on the wrap cycle
    cfg_valid = 1'b1; cfg_div = 8'd2;
    step();
    cfg_valid = 1'b0;
    chk("t7 stop done", 32'(cfg_done), 32'd1);
    chk("t7 stop cur", 32'(cur_div), 32'd2);
    chk("t7 stop state", 32'(dbg_state), 32'(S_STOP));
    en = 1'b1;
    step();
    run_period(2);
    step();                          // cnt=1 (wrap)
    cfg_valid = 1'b1; cfg_div = 8'd3;
    step();                          // cnt=0, PEND
    cfg_valid = 1'b0;
    chk("t7 wrap pend", 32'(dbg_state), 32'(S_PEND));
    chk("t7 wrap tick", 32'(tick), 32'd1);
    chk("t7 wrap cur", 32'(cur_div), 32'd2);
    chk("t7 wrap no done", 32'(cfg_done), 32'd0);
    step();                          // cnt=1
    chk("t7 old clk low", 32'(clk_out), 32'd0);
    step();                          // new ratio
    chk("t7 done", 32'(cfg_done), 32'd1);
    chk("t7 cur 3", 32'(cur_div), 32'd3);
    run_period(3);

    // Final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/clkdiv_ctrl.md
Name: clkdiv_ctrl

Overview:
Programmable clock-divider controller. It generates a divided clock `clk_out` from `sys_clk` with a run-time configurable ratio. Ratio changes are taken through a valid/ready handshake and applied only at a period boundary, so `clk_out` never glitches. Start and stop are also glitch-free. It sits next to the fixed clkdiv blocks and drives slow peripheral enables and clocks.

Parameters:
DIV_W, 8, width of divide ratio and internal counter
DEFAULT_DIV, 10, ratio loaded at reset (must be 2..2^DIV_W-1)

Ports:
sys_clk  input  1  system clock; all logic on its rising edge
sys_rst_n  input  1  reset, synchronous, active-low
en  input  1  run request; 1 = run divider, 0 = stop at next period end
cfg_valid  input  1  new ratio offered
cfg_div  input  DIV_W  requested ratio N
cfg_ready  output  1  controller can accept a ratio this cycle
cfg_err  output  1  one-cycle pulse: accepted ratio rejected (N<2)
cfg_done  output  1  one-cycle pulse: new ratio now in effect
cur_div  output  DIV_W  ratio currently in effect
clk_out  output  1  divided clock, registered
tick  output  1  one-cycle pulse on the cycle clk_out rises (period start)
running  output  1  1 in RUN or PEND

Behaviour:
- Reset: sys_rst_n sampled low at posedge sets:
  - state=STOP, cnt=0, cur_div=DEFAULT_DIV, pend_div=0.
  - clk_out=0, tick=0, cfg_err=0, cfg_done=0, running=0.
  - Reset mid-operation aborts any pending config immediately.
- Period rule, N=cur_div, half=N>>1:
  - cnt runs 0..N-1 and wraps to 0.
  - clk_out is registered as (cnt_next < half): high for half cycles, low for N-half cycles.
  - Example N=5: 2 high, 3 low.
  - Wrap cycle is the cycle with cnt==N-1; clk_out is always 0 there.
- States:
  - STOP: cnt=0, clk_out=0.
    - en=1 → RUN on the next edge, loading cnt=0, clk_out=1, tick=1.
    - Latency en→first clk_out rise: 1 cycle.
  - RUN: counts per period rule; tick=1 on each edge that loads cnt=0.
    - en=0 at wrap cycle → STOP, cnt=0, clk_out stays 0, no tick.
    - en=0 elsewhere → keep counting until wrap; no truncated periods.
  - PEND: counts with old cur_div.
    - At wrap cycle: cur_div<=pend_div, cfg_done=1, cnt=0.
    - If en=1: → RUN, clk_out=1, tick=1.
    - If en=0: → STOP, clk_out=0.
- Config handshake:
  - cfg_ready=1 in STOP and RUN, 0 in PEND.
  - Transfer occurs when cfg_valid&cfg_ready at a posedge.
  - Accepted cfg_div<2 → cfg_err=1 next cycle; no state or cur_div change.
  - Valid in STOP → cur_div<=cfg_div on the same edge, cfg_done=1 next cycle.
  - Valid in RUN → pend_div<=cfg_div, state → PEND.
  - Valid in RUN at the wrap cycle itself → still → PEND; takes effect at the next wrap (full old period first).
- Simultaneous events:
  - cfg transfer and en rising in STOP on the same edge: cur_div updates and RUN starts with the new ratio.
  - cfg_valid held high while in PEND is not accepted; it is accepted on the first cycle after return to RUN.
- Widths: cnt and compare are DIV_W bits; N=2^DIV_W-1 is legal; no overflow since cnt<N.

Test Plan:
1. DEFAULT_DIV=4. Reset low 20ns, en=1 after release → clk_out 1,1,0,0 repeating; tick every 4 cycles; cur_div=4.
2. While running N=4, send cfg_div=6 mid-period → cfg_ready drops next cycle; old period completes; cfg_done at wrap; then clk_out 3 high/3 low; cfg_ready back to 1.
3. cfg_div=1 (and 0) in RUN → cfg_err single pulse; cur_div stays 4; waveform unchanged.
4. Drop en at cnt=1 with N=5 → clk_out finishes 2 high/3 low, then stays 0; running=0 after wrap; no short pulse.
5. In STOP, cfg_div=3 on the same edge as en=1 → first period 1 high/2 low; cfg_done pulses once.
6. Assert sys_rst_n=0 during PEND → next cycle clk_out=0, cur_div=DEFAULT_DIV, state STOP, no cfg_done emitted.
